// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO reader-side drain controller.
package fifo_rd_pkg;

    localparam int RD_DATA_W     = 8;
    localparam int RD_SKID_DEPTH = 2;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} rd_state_e;

    typedef logic [RD_DATA_W-1:0] rd_data_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small register FIFO holding words captured from the sync FIFO read port.
// Head is always entry 0, so the head output is a plain register.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = RD_DATA_W,
    parameter int DEPTH  = RD_SKID_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_ovf
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt;

    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CNT_W-1:0] w_wr_idx;

    always_comb begin
        w_full    = (r_cnt == CNT_W'(DEPTH));
        w_pop_ok  = i_pop && (r_cnt != '0);
        w_push_ok = i_push && (!w_full || w_pop_ok);
        w_wr_idx  = w_pop_ok ? (r_cnt - CNT_W'(1)) : r_cnt;
    end

    // Shift-down on pop; a same-cycle push lands one slot lower so order holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_pop_ok) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            if (w_push_ok) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == w_wr_idx) begin
                        r_mem[i] <= i_data;
                    end
                end
            end
            r_cnt <= r_cnt + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);
        end
    end

    assign o_head = r_mem[0];
    assign o_cnt  = r_cnt;
    assign o_ovf  = i_push && w_full && !w_pop_ok;

endmodule

// File: rtl/fifo_rd_drain.sv
// Reader-side controller: pops the sync FIFO and re-presents words as a valid/ready stream.
// Define FIFO_RD_STATS_EN to add the pop_cnt / stall_cnt statistics outputs.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W     = RD_DATA_W,
    parameter int SKID_DEPTH = RD_SKID_DEPTH
`ifdef FIFO_RD_STATS_EN
    ,
    parameter int CNT_W      = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              pop,
    input  logic [DATA_W-1:0] data_out,
    input  logic              empty,
    input  logic              pop_err_on_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              err
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0]  pop_cnt,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    localparam int SC_W = $clog2(SKID_DEPTH + 1);
    localparam int OC_W = SC_W + 1;

    rd_state_e       r_state;
    logic            r_busy;
    logic            r_inflight;
    logic            r_err;

    logic [SC_W-1:0] w_skid_cnt;
    logic [OC_W-1:0] w_occ;
    logic            w_xfer;
    logic            w_ovf;

    fifo_rd_skid #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_DEPTH),
        .CNT_W  (SC_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_data (data_out),
        .i_pop  (w_xfer),
        .o_head (m_data),
        .o_cnt  (w_skid_cnt),
        .o_ovf  (w_ovf)
    );

    assign m_valid = (w_skid_cnt != '0);

    // The word leaving this cycle frees its slot now, which keeps a ready sink at one word per cycle.
    always_comb begin
        w_xfer = m_valid && m_ready;
        w_occ  = OC_W'(w_skid_cnt) + OC_W'(r_inflight);
        pop    = (r_state == ACTIVE) && en && !empty
                 && (w_occ < (OC_W'(SKID_DEPTH) + OC_W'(w_xfer)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= ACTIVE;
                        r_busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!en) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (en) begin
                        r_state <= ACTIVE;
                    end else if (!r_inflight && (w_skid_cnt == '0)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= pop;
            r_err      <= r_err | pop_err_on_empty | w_ovf;
        end
    end

    assign busy = r_busy;
    assign err  = r_err;

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] r_pop_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (pop && (r_pop_cnt != '1)) begin
                r_pop_cnt <= r_pop_cnt + CNT_W'(1);
            end
            if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pop_cnt   = r_pop_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: FIFO model, stream scoreboard, vector table, corner sequences.
// Build with FIFO_RD_STATS_EN defined to also cover the statistics counters.
module tb_fifo_rd_drain;
    import fifo_rd_pkg::*;

    localparam int DW = RD_DATA_W;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     en = 1'b0;
    logic     pop;
    rd_data_t data_out = '0;
    logic     empty = 1'b1;
    logic     pop_err_on_empty = 1'b0;
    logic     m_valid;
    logic     m_ready = 1'b0;
    rd_data_t m_data;
    logic     busy;
    logic     err;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] pop_cnt;
    logic [15:0] stall_cnt;
`endif

    fifo_rd_drain #(
        .DATA_W     (DW),
        .SKID_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .pop              (pop),
        .data_out         (data_out),
        .empty            (empty),
        .pop_err_on_empty (pop_err_on_empty),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .busy             (busy),
        .err              (err)
`ifdef FIFO_RD_STATS_EN
        ,
        .pop_cnt          (pop_cnt),
        .stall_cnt        (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit en;
        bit rdy;
        bit pop;
        bit valid;
        bit busy;
    } vec_t;

    vec_t     vec [14];
    int       n_vec = 0;
    int       n_miss = 0;
    rd_data_t fq [$];
    rd_data_t exp_q [$];
    logic     force_empty = 1'b0;
    logic     pop_s = 1'b0;
    int       pops_seen = 0;
    int       delivered = 0;
    logic     prev_hold = 1'b0;
    rd_data_t prev_data = '0;
    logic     last_busy = 1'b0;
    logic     last_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Negedge: sample outputs, scoreboard the stream, check no pop on empty and hold rules.
    task automatic half_a();
        @(negedge clk);
        pop_s      = pop;
        last_busy  = busy;
        last_valid = m_valid;
        if (pop) pops_seen++;
        if (empty) chk("no_pop_on_empty", 32'(pop), 32'd0);
        if (prev_hold) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_word: got %0h expected none (t=%0t)", m_data, $time);
            end else begin
                chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            delivered++;
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
    endtask

    // Just after posedge: FIFO model presents the popped word for one cycle.
    task automatic half_b();
        @(posedge clk);
        #1;
        if (pop_s && (fq.size() > 0)) begin
            data_out = fq.pop_front();
            exp_q.push_back(data_out);
        end else begin
            data_out = DW'($urandom);
        end
        empty = force_empty || (fq.size() == 0);
    endtask

    task automatic tick();
        half_a();
        half_b();
    endtask

    task automatic load(input int n, input rd_data_t base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            fq.push_back(rnd ? DW'($urandom) : base + DW'(i));
        end
        empty = force_empty || (fq.size() == 0);
    endtask

    task automatic set_force(input logic b);
        force_empty = b;
        empty = force_empty || (fq.size() == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        m_ready = 1'b0;
        pop_err_on_empty = 1'b0;
        force_empty = 1'b0;
        fq.delete();
        exp_q.delete();
        empty = 1'b1;
        data_out = '0;
        pop_s = 1'b0;
        pops_seen = 0;
        delivered = 0;
        prev_hold = 1'b0;
        last_busy = 1'b0;
        last_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected summary");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int   p0;
        logic seen;

        // cycle-by-cycle: 8 preloaded words at full rate, then en low and drain to idle
        vec[0]  = '{1, 1, 0, 0, 0};
        vec[1]  = '{1, 1, 1, 0, 1};
        vec[2]  = '{1, 1, 1, 0, 1};
        vec[3]  = '{1, 1, 1, 1, 1};
        vec[4]  = '{1, 1, 1, 1, 1};
        vec[5]  = '{1, 1, 1, 1, 1};
        vec[6]  = '{1, 1, 1, 1, 1};
        vec[7]  = '{1, 1, 1, 1, 1};
        vec[8]  = '{1, 1, 1, 1, 1};
        vec[9]  = '{1, 1, 0, 1, 1};
        vec[10] = '{1, 1, 0, 1, 1};
        vec[11] = '{0, 1, 0, 0, 1};
        vec[12] = '{0, 1, 0, 0, 1};
        vec[13] = '{0, 1, 0, 0, 0};

        do_reset();
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Stream at full rate
        load(8, 8'h11, 1'b0);
        for (int i = 0; i < 14; i++) begin
            en = vec[i].en;
            m_ready = vec[i].rdy;
            half_a();
            chk($sformatf("row%0d_pop", i), 32'(pop), 32'(vec[i].pop));
            chk($sformatf("row%0d_valid", i), 32'(m_valid), 32'(vec[i].valid));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(vec[i].busy));
            half_b();
        end
        chk("stream_delivered", 32'(delivered), 32'd8);
        chk("stream_pops", 32'(pops_seen), 32'd8);
        chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: sink stalled, pops stop at skid capacity
        do_reset();
        load(8, 8'h11, 1'b0);
        en = 1'b1;
        m_ready = 1'b0;
        repeat (8) tick();
        chk("bp_pops", 32'(pops_seen), 32'd2);
        chk("bp_head", 32'(m_data), 32'h11);
        m_ready = 1'b1;
        for (int k = 0; k < 30 && delivered < 8; k++) tick();
        chk("bp_delivered", 32'(delivered), 32'd8);
        chk("bp_total_pops", 32'(pops_seen), 32'd8);

        // Drain: en low right after the first pop
        do_reset();
        load(4, 8'h21, 1'b0);
        en = 1'b1;
        m_ready = 1'b1;
        tick();
        tick();
        en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (!last_busy) seen = 1'b1;
        end
        chk("drain_idle", 32'(seen), 32'd1);
        chk("drain_pops", 32'(pops_seen), 32'd1);
        chk("drain_delivered", 32'(delivered), 32'd1);
        en = 1'b1;
        tick();
        chk("reactivate_busy", 32'(busy), 32'd1);
        chk("reactivate_pop", 32'(pop), 32'd1);
        for (int k = 0; k < 20 && delivered < 4; k++) tick();
        chk("reactivate_delivered", 32'(delivered), 32'd4);
        en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (!last_busy) seen = 1'b1;
        end
        chk("final_idle", 32'(seen), 32'd1);

        // Error flag and random empty toggling
        do_reset();
        load(40, '0, 1'b1);
        en = 1'b1;
        m_ready = 1'b1;
        repeat (4) tick();
        chk("err_clear", 32'(err), 32'd0);
        pop_err_on_empty = 1'b1;
        tick();
        pop_err_on_empty = 1'b0;
        chk("err_set", 32'(err), 32'd1);
        for (int k = 0; k < 60; k++) begin
            set_force(1'($urandom_range(0, 1)));
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("err_sticky", 32'(err), 32'd1);
        set_force(1'b0);
        m_ready = 1'b1;
        for (int k = 0; k < 100 && ((fq.size() != 0) || (exp_q.size() != 0) || last_valid); k++) tick();
        chk("rand_fifo_drained", 32'(fq.size()), 32'd0);
        chk("rand_sb_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two words buffered
        p0 = pops_seen;
        load(4, 8'h31, 1'b0);
        m_ready = 1'b0;
        repeat (6) tick();
        chk("pre_rst_pops", 32'(pops_seen - p0), 32'd2);
        chk("pre_rst_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_pop", 32'(pop), 32'd0);
        chk("async_rst_valid", 32'(m_valid), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_err", 32'(err), 32'd0);
        do_reset();

`ifdef FIFO_RD_STATS_EN
        // Statistics: 4 words, sink stalled 3 cycles with data valid
        load(4, 8'h41, 1'b0);
        en = 1'b1;
        m_ready = 1'b0;
        for (int k = 0; k < 10 && !last_valid; k++) tick();
        tick();
        tick();
        m_ready = 1'b1;
        for (int k = 0; k < 20 && delivered < 4; k++) tick();
        chk("stats_delivered", 32'(delivered), 32'd4);
        chk("stats_pop_cnt", 32'(pop_cnt), 32'd4);
        chk("stats_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
